// File: rtl/mem_arbiter.sv
// Two-master (CPU = m0, DMA = m1) arbiter onto one shared slave bus.
// Alternates on contention, locks for a whole transfer, and force-completes stalled transfers.
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,

  output logic [1:0]  grant,
  output logic        timeout_err
);

  // Handshake: a requester holds valid and its fields stable until ready; the
  // transfer completes in the cycle ready is 1, and valid may drop the cycle after.

  // The state encoding is the one-hot grant, so grant doubles as the FSM debug view.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] wait_cnt;
  logic        last_m1;
  logic        own_valid;
  logic        timeout_hit;

  always_comb begin
    own_valid = 1'b0;
    case (state)
      OWN0:    own_valid = m0_valid;
      OWN1:    own_valid = m1_valid;
      default: own_valid = 1'b0;
    endcase
    // A same-cycle s_ready always beats the timeout.
    timeout_hit = (state != IDLE) && own_valid && !s_ready && (wait_cnt == WAIT_LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= 16'd0;
      last_m1  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        wait_cnt <= 16'd0;
      end else if (!s_ready) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
      if ((state != IDLE) && (state_nxt == IDLE)) begin
        last_m1 <= (state == OWN1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0_valid && m1_valid) begin
          state_nxt = last_m1 ? OWN0 : OWN1;
        end else if (m0_valid) begin
          state_nxt = OWN0;
        end else if (m1_valid) begin
          state_nxt = OWN1;
        end
      end
      // Every ownership ends in IDLE, which guarantees a gap cycle between transfers.
      OWN0, OWN1: begin
        if (!own_valid || s_ready || timeout_hit) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant       = state;
    timeout_err = timeout_hit;
    s_valid     = 1'b0;
    s_addr      = 32'd0;
    s_wdata     = 32'd0;
    s_wstrb     = 4'd0;
    m0_ready    = 1'b0;
    m0_rdata    = 32'd0;
    m1_ready    = 1'b0;
    m1_rdata    = 32'd0;
    case (state)
      OWN0: begin
        s_valid  = m0_valid && !timeout_hit;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_wstrb  = m0_wstrb;
        m0_ready = timeout_hit || (s_ready && m0_valid);
        m0_rdata = timeout_hit ? 32'hFFFF_FFFF : s_rdata;
      end
      OWN1: begin
        s_valid  = m1_valid && !timeout_hit;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_wstrb  = m1_wstrb;
        m1_ready = timeout_hit || (s_ready && m1_valid);
        m1_rdata = timeout_hit ? 32'hFFFF_FFFF : s_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized masters/slave,
// all checked against a cycle-level ownership model kept in the bench.
module tb_mem_arbiter;

  localparam int TB_TIMEOUT = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        m0_valid, m0_ready, m1_valid, m1_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;
  logic        timeout_err;

  mem_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: -1 = nobody, else master index; waited = stalled cycles so far.
  int   mdl_owner;
  int   mdl_wait;
  int   mdl_last;
  logic last_ready[2];

  task automatic model_reset();
    mdl_owner = -1;
    mdl_wait  = 0;
    mdl_last  = 1;
  endtask

  // Called just after a negedge once inputs are set: compares all outputs, then advances the model.
  task automatic check_cycle();
    logic        v[2];
    logic [31:0] a[2], d[2];
    logic [3:0]  st[2];
    logic        er[2];
    logic [31:0] erd[2];
    logic [1:0]  eg;
    logic        ev, timed_out;
    logic [31:0] ea, ed;
    logic [3:0]  es;
    int          x;
    #1;
    v[0] = m0_valid; a[0] = m0_addr; d[0] = m0_wdata; st[0] = m0_wstrb;
    v[1] = m1_valid; a[1] = m1_addr; d[1] = m1_wdata; st[1] = m1_wstrb;
    eg = 2'b00; ev = 1'b0; ea = 32'd0; ed = 32'd0; es = 4'd0; timed_out = 1'b0;
    for (int m = 0; m < 2; m++) begin
      er[m] = 1'b0;
      erd[m] = 32'd0;
    end
    x = mdl_owner;
    if (x >= 0) begin
      timed_out = v[x] && !s_ready && (mdl_wait == TB_TIMEOUT - 1);
      eg[x]  = 1'b1;
      ev     = v[x] && !timed_out;
      ea     = a[x];
      ed     = d[x];
      es     = st[x];
      er[x]  = timed_out || (s_ready && v[x]);
      erd[x] = timed_out ? 32'hFFFF_FFFF : s_rdata;
    end
    check("grant",       32'(grant),       32'(eg));
    check("s_valid",     32'(s_valid),     32'(ev));
    check("s_addr",      s_addr,           ea);
    check("s_wdata",     s_wdata,          ed);
    check("s_wstrb",     32'(s_wstrb),     32'(es));
    check("m0_ready",    32'(m0_ready),    32'(er[0]));
    check("m1_ready",    32'(m1_ready),    32'(er[1]));
    check("m0_rdata",    m0_rdata,         erd[0]);
    check("m1_rdata",    m1_rdata,         erd[1]);
    check("timeout_err", 32'(timeout_err), 32'(timed_out));
    last_ready[0] = er[0];
    last_ready[1] = er[1];
    if (x < 0) begin
      mdl_wait = 0;
      if (v[0] && v[1])  mdl_owner = (mdl_last == 1) ? 0 : 1;
      else if (v[0])     mdl_owner = 0;
      else if (v[1])     mdl_owner = 1;
    end else if (!v[x] || s_ready || timed_out) begin
      mdl_last  = x;
      mdl_owner = -1;
    end else begin
      mdl_wait++;
    end
  endtask

  // ---------------- drivers ----------------
  logic        pend[2];
  logic [31:0] f_addr[2], f_wdata[2];
  logic [3:0]  f_wstrb[2];

  task automatic drive_masters();
    m0_valid = pend[0]; m0_addr = f_addr[0]; m0_wdata = f_wdata[0]; m0_wstrb = f_wstrb[0];
    m1_valid = pend[1]; m1_addr = f_addr[1]; m1_wdata = f_wdata[1]; m1_wstrb = f_wstrb[1];
  endtask

  task automatic do_reset();
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0; f_addr[m] = 32'd0; f_wdata[m] = 32'd0; f_wstrb[m] = 4'd0;
    end
    drive_masters();
    s_ready = 1'b0;
    s_rdata = 32'd0;
    rst_n   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("reset_grant",   32'(grant),       32'd0);
    check("reset_s_valid", 32'(s_valid),     32'd0);
    check("reset_err",     32'(timeout_err), 32'd0);
    rst_n = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int m0_n;

    // Simultaneous request right after reset: m0 first, m1 after a gap cycle.
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h0000_0040; m0_wstrb = 4'd0;
    m1_valid = 1'b1; m1_addr = 32'h0000_0080; m1_wstrb = 4'd0;
    check_cycle();
    check("r031_c0_grant", 32'(grant), 32'd0);
    @(negedge clk); check_cycle();
    check("r031_c1_grant", 32'(grant), 32'h1);
    @(negedge clk); check_cycle();
    @(negedge clk); s_ready = 1'b1; s_rdata = 32'hA5A5_0003; check_cycle();
    check("r031_c3_m0_ready", 32'(m0_ready), 32'h1);
    @(negedge clk); m0_valid = 1'b0; s_ready = 1'b0; check_cycle();
    check("r031_c4_grant", 32'(grant), 32'd0);
    @(negedge clk); s_ready = 1'b1; check_cycle();
    check("r031_c5_grant", 32'(grant), 32'h2);
    @(negedge clk); m1_valid = 1'b0; s_ready = 1'b0; check_cycle();
    @(negedge clk);

    // m0 issues three back-to-back reads while m1 requests continuously.
    do_reset();
    exp_q = {2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    m0_n = 0;
    for (int c = 0; c < 12; c++) begin
      m0_valid = (m0_n < 3);
      m0_addr  = 32'h0000_0100 + 32'(m0_n * 4);
      m0_wstrb = 4'd0;
      m1_valid = 1'b1;
      m1_addr  = 32'h0000_0200 + 32'(c);
      s_ready  = 1'b1;
      s_rdata  = $urandom;
      check_cycle();
      if (c >= 1) check("r032_order", 32'(grant), 32'(exp_q.pop_front()));
      if (last_ready[0]) m0_n++;
      @(negedge clk);
    end
    check("r032_m0_count", 32'(m0_n), 32'd3);

    // m1 write fields pass through unchanged; m0 sees nothing.
    do_reset();
    m1_valid = 1'b1; m1_addr = 32'h0000_1004; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'b1111;
    check_cycle();
    @(negedge clk); s_ready = 1'b1; check_cycle();
    check("r033_s_addr",   s_addr,          32'h0000_1004);
    check("r033_s_wdata",  s_wdata,         32'hDEAD_BEEF);
    check("r033_s_wstrb",  32'(s_wstrb),    32'hF);
    check("r033_m0_ready", 32'(m0_ready),   32'd0);
    check("r033_m1_ready", 32'(m1_ready),   32'h1);
    @(negedge clk); m1_valid = 1'b0; s_ready = 1'b0; check_cycle();
    @(negedge clk);

    // Slave never ready: forced completion in the 4th owned cycle.
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h0000_0300; m0_wstrb = 4'd0;
    check_cycle();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); check_cycle();
      if (k < 4) check("r034_no_err_early", 32'(timeout_err), 32'd0);
    end
    check("r034_m0_ready", 32'(m0_ready),    32'h1);
    check("r034_err",      32'(timeout_err), 32'h1);
    check("r034_rdata",    m0_rdata,         32'hFFFF_FFFF);
    check("r034_s_valid",  32'(s_valid),     32'd0);
    @(negedge clk); m0_valid = 1'b0; check_cycle();
    check("r034_idle", 32'(grant), 32'd0);
    @(negedge clk);

    // Slave ready exactly at the timeout cycle: normal completion wins.
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h0000_0304; m0_wstrb = 4'd0;
    check_cycle();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 4) begin s_ready = 1'b1; s_rdata = 32'h1234_5678; end
      check_cycle();
    end
    check("r035_m0_ready", 32'(m0_ready),    32'h1);
    check("r035_err",      32'(timeout_err), 32'd0);
    check("r035_rdata",    m0_rdata,         32'h1234_5678);
    @(negedge clk); m0_valid = 1'b0; s_ready = 1'b0; check_cycle();
    check("r035_idle", 32'(grant), 32'd0);
    @(negedge clk);

    // Asynchronous reset in the middle of an m1 transfer.
    do_reset();
    m1_valid = 1'b1; m1_addr = 32'h0000_0400;
    check_cycle();
    @(negedge clk); check_cycle();
    check("r036_own1", 32'(grant), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("r036_grant_async",   32'(grant),    32'd0);
    check("r036_s_valid_async", 32'(s_valid),  32'd0);
    check("r036_m1_ready",      32'(m1_ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    m0_valid = 1'b1; m1_valid = 1'b1;
    check_cycle();
    @(negedge clk); check_cycle();
    check("r036_post_reset_m0", 32'(grant), 32'h1);
    @(negedge clk);

    // Randomized traffic, including immediate re-requests and occasional aborts.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m]) begin
          if ($urandom_range(0, 2) != 0) begin
            pend[m]    = 1'b1;
            f_addr[m]  = $urandom;
            f_wdata[m] = $urandom;
            f_wstrb[m] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
          end
        end else if ($urandom_range(0, 39) == 0) begin
          pend[m] = 1'b0;
        end
      end
      drive_masters();
      s_ready = ($urandom_range(0, 3) == 0);
      s_rdata = $urandom;
      check_cycle();
      for (int m = 0; m < 2; m++) if (last_ready[m]) pend[m] = 1'b0;
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
